// File: rtl/cn_sched.sv
// -----------------------------------------------------------------------------
// cn_sched
//
// Schedules one shared degree-6 min-sum check-node (CN) unit across all NUM_CN
// check nodes of a QKD LDPC code. Each iteration runs a flooding schedule:
//   1. ISSUE: sweep over the check nodes. Read address k goes out on each
//      cycle that the message RAM is not stalled.
//   2. DRAIN: wait for the CN unit pipeline (fixed CN_LAT latency) to retire
//      its last result.
//   3. VWAIT: pulse vn_start, then wait for the variable-node phase to report
//      vn_done together with the syndrome flag syn_ok.
// Iterations repeat until the iteration limit is reached, or until parity is
// satisfied when early termination is compiled in.
//
// Optional feature macro: CN_SCHED_EARLY_TERM_EN
//   defined   : syn_ok=1 at vn_done ends decoding with converged=1.
//   undefined : decoding always runs exactly L iterations, and converged
//               takes the syn_ok value seen at the final vn_done.
//
// Ports:
//   clk, rst          clock (rising edge) and asynchronous active-high reset
//   start             begin decode; accepted only while idle
//   max_iter_cfg      iteration limit, sampled on start; 0 selects MAX_ITER
//   stall             message RAM not ready; holds back issue only
//   rd_en, rd_addr    read the inputs of check node rd_addr this cycle
//   wr_en, wr_addr    write the CN results of check node wr_addr this cycle
//   vn_start          one-cycle pulse that starts the variable-node phase
//   vn_done, syn_ok   end of the variable-node phase and its syndrome result
//   busy              high whenever the scheduler is not idle
//   done              one-cycle pulse when decoding completes
//   converged         result flag, valid from done until the next start
//   iter_count        completed iterations, valid with done
// -----------------------------------------------------------------------------
module cn_sched #(
  parameter int NUM_CN   = 64,
  parameter int ADDR_W   = 6,
  parameter int CN_LAT   = 2,
  parameter int ITER_W   = 5,
  parameter int MAX_ITER = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ITER_W-1:0] max_iter_cfg,
  input  logic              stall,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              vn_start,
  input  logic              vn_done,
  input  logic              syn_ok,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic [ITER_W-1:0] iter_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DRAIN = 3'd2,
    S_VWAIT = 3'd3,
    S_FIN   = 3'd4
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(NUM_CN - 1);
  localparam logic [ITER_W-1:0] MAX_L  = ITER_W'(MAX_ITER);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   k_q, k_d;
  logic [ITER_W-1:0]   limit_q, limit_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic                conv_q, conv_d;
  logic                vn_start_q, vn_start_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  // Latency pipeline: stage 0 is loaded by the issue slot; stage CN_LAT-1
  // is the tail that drives the write port.
  logic                pipe_vld_q  [CN_LAT];
  logic                pipe_vld_d  [CN_LAT];
  logic [ADDR_W-1:0]   pipe_addr_q [CN_LAT];
  logic [ADDR_W-1:0]   pipe_addr_d [CN_LAT];

  logic                issue;
  logic                drain_last;
  logic [ITER_W-1:0]   iter_inc;

  // Issue slot. This has to follow stall in the same cycle, so it is decoded
  // from registered state and is not registered itself.
  always_comb begin
    issue = (state_q == S_ISSUE) && !stall;
  end

  // Shift the pipeline every cycle, whatever stall is doing.
  always_comb begin
    pipe_vld_d[0]  = issue;
    pipe_addr_d[0] = k_q;
    for (int i = 1; i < CN_LAT; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_addr_d[i] = pipe_addr_q[i-1];
    end
  end

  // Nothing is issued during DRAIN. When every stage ahead of the tail is
  // empty, the current cycle carries the last write (if any), so vn_start
  // may follow in the next cycle.
  always_comb begin
    drain_last = 1'b1;
    for (int i = 0; i < CN_LAT - 1; i++) begin
      drain_last = drain_last & ~pipe_vld_q[i];
    end
  end

  // Next-state and registered-output logic of the scheduler FSM.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    limit_d    = limit_q;
    iter_d     = iter_q;
    conv_d     = conv_q;
    vn_start_d = 1'b0;
    done_d     = 1'b0;
    iter_inc   = iter_q + ITER_W'(1);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          limit_d = (max_iter_cfg == {ITER_W{1'b0}}) ? MAX_L : max_iter_cfg;
          iter_d  = {ITER_W{1'b0}};
          conv_d  = 1'b0;
          k_d     = {ADDR_W{1'b0}};
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (!stall) begin
          if (k_q == LAST_K) begin
            // Wrap now so the next sweep starts from check node 0.
            k_d     = {ADDR_W{1'b0}};
            state_d = S_DRAIN;
          end else begin
            k_d = k_q + ADDR_W'(1);
          end
        end else begin
          k_d = k_q;
        end
      end
      S_DRAIN: begin
        if (drain_last) begin
          vn_start_d = 1'b1;
          state_d    = S_VWAIT;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_VWAIT: begin
        if (vn_done) begin
          iter_d = iter_inc;
`ifdef CN_SCHED_EARLY_TERM_EN
          if (syn_ok) begin
            conv_d  = 1'b1;
            done_d  = 1'b1;
            state_d = S_FIN;
          end else if (iter_inc == limit_q) begin
            conv_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_FIN;
          end else begin
            state_d = S_ISSUE;
          end
`else
          if (iter_inc == limit_q) begin
            conv_d  = syn_ok;
            done_d  = 1'b1;
            state_d = S_FIN;
          end else begin
            state_d = S_ISSUE;
          end
`endif
        end else begin
          state_d = S_VWAIT;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      k_q        <= {ADDR_W{1'b0}};
      limit_q    <= {ITER_W{1'b0}};
      iter_q     <= {ITER_W{1'b0}};
      conv_q     <= 1'b0;
      vn_start_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      limit_q    <= limit_d;
      iter_q     <= iter_d;
      conv_q     <= conv_d;
      vn_start_q <= vn_start_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  // Latency pipeline registers. Reset discards any writes still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CN_LAT; i++) begin
        pipe_vld_q[i]  <= 1'b0;
        pipe_addr_q[i] <= {ADDR_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < CN_LAT; i++) begin
        pipe_vld_q[i]  <= pipe_vld_d[i];
        pipe_addr_q[i] <= pipe_addr_d[i];
      end
    end
  end

  assign rd_en      = issue;
  assign rd_addr    = k_q;
  assign wr_en      = pipe_vld_q[CN_LAT-1];
  assign wr_addr    = pipe_addr_q[CN_LAT-1];
  assign vn_start   = vn_start_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign converged  = conv_q;
  assign iter_count = iter_q;

endmodule

// File: tb/tb_cn_sched.sv
// -----------------------------------------------------------------------------
// tb_cn_sched
//
// Self-checking bench for cn_sched with NUM_CN=4 and CN_LAT=2. For each decode
// the bench plans the stimulus (stall cycles, vn_done/syn_ok responses and
// spurious inputs) and derives the expected read, write, vn_start and done
// events from the scheduling rules. These events go into scoreboard queues
// and are popped when the DUT produces the matching output. Expected results
// follow CN_SCHED_EARLY_TERM_EN in the same way the design does.
// -----------------------------------------------------------------------------
module tb_cn_sched;

  localparam int NUM_CN = 4;
  localparam int ADDR_W = 2;
  localparam int CN_LAT = 2;
  localparam int ITER_W = 5;
  localparam int PL     = 512;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ITER_W-1:0] max_iter_cfg;
  logic              stall;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              vn_start;
  logic              vn_done;
  logic              syn_ok;
  logic              busy;
  logic              done;
  logic              converged;
  logic [ITER_W-1:0] iter_count;

  cn_sched #(
    .NUM_CN  (NUM_CN),
    .ADDR_W  (ADDR_W),
    .CN_LAT  (CN_LAT),
    .ITER_W  (ITER_W),
    .MAX_ITER(20)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .max_iter_cfg(max_iter_cfg),
    .stall       (stall),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .vn_start    (vn_start),
    .vn_done     (vn_done),
    .syn_ok      (syn_ok),
    .busy        (busy),
    .done        (done),
    .converged   (converged),
    .iter_count  (iter_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int val;
    int aux;
  } ev_t;

  ev_t rd_q[$];
  ev_t wr_q[$];
  ev_t vs_q[$];
  ev_t dn_q[$];

  // Per-cycle stimulus plan, indexed by the cycle number within a decode.
  bit stall_pl [PL];
  bit vnd_pl   [PL];
  bit syn_pl   [PL];
  bit start_pl [PL];
  int hold_pl  [PL];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr_plan();
    for (int i = 0; i < PL; i++) begin
      stall_pl[i] = 1'b0;
      vnd_pl[i]   = 1'b0;
      syn_pl[i]   = 1'b0;
      start_pl[i] = 1'b0;
      hold_pl[i]  = -1;
    end
    rd_q.delete();
    wr_q.delete();
    vs_q.delete();
    dn_q.delete();
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_rd_en"},    rd_en,      0);
    chk({pfx, "_rd_addr"},  rd_addr,    0);
    chk({pfx, "_wr_en"},    wr_en,      0);
    chk({pfx, "_wr_addr"},  wr_addr,    0);
    chk({pfx, "_vn_start"}, vn_start,   0);
    chk({pfx, "_busy"},     busy,       0);
    chk({pfx, "_done"},     done,       0);
    chk({pfx, "_conv"},     converged,  0);
    chk({pfx, "_iter"},     iter_count, 0);
  endtask

  // One decode. Cycle 0 carries start; sweep s reads are syn_ok=1 when
  // syn_from <= s <= syn_to. vn_done is returned two cycles after vn_start.
  task automatic run(input int cfg, input int syn_from, input int syn_to, input bit start_at_done);
    int lim, c, last, vs, vd, base, iters, s, done_cyc, end_cyc;
    bit sy, conv, fin;
    ev_t e;
    lim   = (cfg == 0) ? 20 : cfg;
    base  = 0;
    iters = 0;
    conv  = 1'b0;
    fin   = 1'b0;
    s     = 0;
    vd    = 0;
    while (!fin) begin
      c    = base + 1;
      last = c;
      for (int k = 0; k < NUM_CN; k++) begin
        while (stall_pl[c]) c++;
        rd_q.push_back('{c, k, 0});
        wr_q.push_back('{c + CN_LAT, k, 0});
        last = c;
        c++;
      end
      vs = last + CN_LAT + 1;
      vs_q.push_back('{vs, 0, 0});
      vd = vs + 2;
      sy = (s >= syn_from) && (s <= syn_to);
      vnd_pl[vd] = 1'b1;
      syn_pl[vd] = sy;
      iters++;
`ifdef CN_SCHED_EARLY_TERM_EN
      if (sy) begin
        conv = 1'b1;
        fin  = 1'b1;
      end else if (iters == lim) begin
        conv = 1'b0;
        fin  = 1'b1;
      end
`else
      if (iters == lim) begin
        conv = sy;
        fin  = 1'b1;
      end
`endif
      base = vd;
      s++;
    end
    done_cyc = vd + 1;
    dn_q.push_back('{done_cyc, iters, int'(conv)});
    if (start_at_done) start_pl[done_cyc] = 1'b1;
    end_cyc = done_cyc + 3;

    for (int rel = 0; rel <= end_cyc; rel++) begin
      @(posedge clk);
      #1;
      start        = (rel == 0) || start_pl[rel];
      // After cycle 0 the configuration is garbage; only the sampled limit counts.
      max_iter_cfg = (rel == 0) ? ITER_W'(cfg) : 5'd31;
      stall        = stall_pl[rel];
      vn_done      = vnd_pl[rel];
      syn_ok       = syn_pl[rel];
      @(negedge clk);
      if (rd_en) begin
        if (rd_q.size() == 0) chk("rd_extra", rel, 0);
        else begin
          e = rd_q.pop_front();
          chk("rd_cyc", rel, e.cyc);
          chk("rd_addr", rd_addr, e.val);
        end
      end
      if (wr_en) begin
        if (wr_q.size() == 0) chk("wr_extra", rel, 0);
        else begin
          e = wr_q.pop_front();
          chk("wr_cyc", rel, e.cyc);
          chk("wr_addr", wr_addr, e.val);
        end
      end
      if (vn_start) begin
        if (vs_q.size() == 0) chk("vs_extra", rel, 0);
        else begin
          e = vs_q.pop_front();
          chk("vs_cyc", rel, e.cyc);
        end
      end
      if (done) begin
        if (dn_q.size() == 0) chk("done_extra", rel, 0);
        else begin
          e = dn_q.pop_front();
          chk("done_cyc", rel, e.cyc);
          chk("done_iter", iter_count, e.val);
          chk("done_conv", converged, e.aux);
        end
      end
      chk("busy", busy, (rel >= 1) && (rel <= done_cyc));
      if (hold_pl[rel] >= 0) begin
        chk("stall_rd_en", rd_en, 0);
        chk("stall_addr", rd_addr, hold_pl[rel]);
      end
    end
    chk("rd_left", rd_q.size(), 0);
    chk("wr_left", wr_q.size(), 0);
    chk("vs_left", vs_q.size(), 0);
    chk("done_left", dn_q.size(), 0);
    chk("iter_hold", iter_count, iters);
    chk("conv_hold", converged, int'(conv));
    start   = 1'b0;
    stall   = 1'b0;
    vn_done = 1'b0;
    syn_ok  = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    max_iter_cfg = '0;
    stall        = 1'b0;
    vn_done      = 1'b0;
    syn_ok       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("rst");
    @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of a sweep, then a fresh decode from address 0.
    clr_plan();
    @(posedge clk); #1;
    start        = 1'b1;
    max_iter_cfg = 5'd3;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("mid_rd_en", rd_en, 1);
    chk("mid_rd_addr", rd_addr, 2);
    #1 rst = 1'b1;
    #1;
    chk_all_zero("mid_rst");
    #1 rst = 1'b0;
    clr_plan();
    run(2, 99, 99, 1'b0);

    // Basic sweep timing; iteration limit reached without convergence.
    clr_plan();
    run(3, 99, 99, 1'b0);

    // Parity satisfied after the first variable-node phase.
    clr_plan();
    run(3, 0, 0, 1'b0);

    // max_iter_cfg = 0 selects the default limit of 20.
    clr_plan();
    run(0, 99, 99, 1'b0);

    // Stall for three cycles after address 1 is issued.
    clr_plan();
    for (int i = 3; i <= 5; i++) begin
      stall_pl[i] = 1'b1;
      hold_pl[i]  = 2;
    end
    run(1, 99, 99, 1'b0);

    // Spurious vn_done in ISSUE, start in VWAIT, start in the done cycle.
    clr_plan();
    vnd_pl[2]   = 1'b1;
    syn_pl[2]   = 1'b1;
    start_pl[8] = 1'b1;
    run(2, 99, 99, 1'b1);

    // syn_ok high on every variable-node phase.
    clr_plan();
    run(2, 0, 99, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
